// File: rtl/sram_march_tester.sv
// sram_march_tester: March C- subset BIST sequencer for dpram_gen; define MARCH_ERR_CAPTURE_EN to build first-error capture.
module sram_march_tester #(
    parameter int addr_w = 8,
    parameter int data_w = 18,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [data_w-1:0] pattern,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_count,
    output logic [addr_w-1:0] first_err_addr,
    output logic [data_w-1:0] first_err_data,
    output logic              ram_we,
    output logic              ram_re,
    output logic [addr_w-1:0] ram_addrA,
    output logic [addr_w-1:0] ram_addrB,
    output logic [data_w-1:0] ram_dA,
    input  logic [data_w-1:0] ram_dB
);
    typedef enum logic [2:0] {IDLE, W0, R0W1, R1W0, R0, DRAIN, DONE} state_t;
    localparam logic [addr_w-1:0] amax = '1;
    state_t state, state_n;
    logic [addr_w-1:0] addr;
    logic sub, rw, accept, miss;
    logic [2:0] dcnt;
    logic [data_w-1:0] pat;
    logic [15:0] err_n;
    logic pv [RD_LAT];
    logic [data_w-1:0] pe [RD_LAT];
    always_comb begin
        rw = state == R0W1 || state == R1W0;
        accept = start && (state == IDLE || state == DONE);
        ram_we = state == W0 || (rw && sub);
        ram_re = state == R0 || (rw && !sub);
        ram_addrA = addr;
        ram_addrB = addr;
        ram_dA = state == R0W1 ? ~pat : pat;
        busy = state inside {W0, R0W1, R1W0, R0, DRAIN};
        miss = pv[RD_LAT-1] && ram_dB != pe[RD_LAT-1];
        err_n = (miss && err_count != 16'hFFFF) ? err_count + 16'd1 : err_count;
        state_n = state;
        case (state)
            IDLE, DONE: state_n = start ? W0 : state;
            W0:         state_n = addr == amax ? R0W1 : W0;
            R0W1:       state_n = (sub && addr == amax) ? R1W0 : R0W1;
            R1W0:       state_n = (sub && addr == '0) ? R0 : R1W0;
            R0:         state_n = addr == amax ? DRAIN : R0;
            DRAIN:      state_n = dcnt == 3'(RD_LAT - 1) ? DONE : DRAIN;
            default:    state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            addr <= '0;
            sub <= 1'b0;
            dcnt <= 3'd0;
            pat <= '0;
            done <= 1'b0;
            pass <= 1'b0;
            err_count <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pv[i] <= 1'b0;
                pe[i] <= '0;
            end
        end else begin
            state <= state_n;
            dcnt <= state == DRAIN ? dcnt + 3'd1 : 3'd0;
            sub <= rw ? ~sub : 1'b0;
            done <= state_n == DONE;
            err_count <= accept ? '0 : err_n;
            // wraps end the element: R0W1 parks at N-1 and R1W0 at 0 for the next element
            if (accept) begin
                addr <= '0;
                pat <= pattern;
                pass <= 1'b0;
            end else if (state == W0 || state == R0 || (state == R0W1 && sub && addr != amax))
                addr <= addr + addr_w'(1);
            else if (state == R1W0 && sub && addr != '0)
                addr <= addr - addr_w'(1);
            if (state == DRAIN && state_n == DONE)
                pass <= err_n == '0;
            pv[0] <= ram_re;
            pe[0] <= state == R1W0 ? ~pat : pat;
            for (int i = 1; i < RD_LAT; i++) begin
                pv[i] <= pv[i-1];
                pe[i] <= pe[i-1];
            end
        end
    end
`ifdef MARCH_ERR_CAPTURE_EN
    logic [addr_w-1:0] pa [RD_LAT];
    always_ff @(posedge clk) begin
        if (rst || accept) begin
            first_err_addr <= '0;
            first_err_data <= '0;
        end else if (miss && err_count == '0) begin
            first_err_addr <= pa[RD_LAT-1];
            first_err_data <= ram_dB;
        end
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++)
                pa[i] <= '0;
        end else begin
            pa[0] <= addr;
            for (int i = 1; i < RD_LAT; i++)
                pa[i] <= pa[i-1];
        end
    end
`else
    assign first_err_addr = '0;
    assign first_err_data = '0;
`endif
endmodule

// File: tb/tb_sram_march_tester.sv
// tb_sram_march_tester: directed bench with behavioural RAMs and a RAM-port access scoreboard.
module tb_sram_march_tester;
    localparam int AW = 4, DW = 18, N = 16;
`ifdef MARCH_ERR_CAPTURE_EN
    localparam logic [AW-1:0] EXP_FEA = 4'd5;
    localparam logic [DW-1:0] EXP_FED = 18'h00001;
`else
    localparam logic [AW-1:0] EXP_FEA = 4'd0;
    localparam logic [DW-1:0] EXP_FED = 18'h00000;
`endif
    logic clk = 0, rst = 1, start = 0, start3 = 0, fault = 0;
    logic [DW-1:0] pattern = '0;
    always #5 clk = ~clk;

    logic busy, done, pass, we, re;
    logic [15:0] err;
    logic [AW-1:0] fea, aA, aB;
    logic [DW-1:0] fed, dA, dB;
    logic [DW-1:0] mem1 [N];
    sram_march_tester #(.addr_w(AW), .data_w(DW), .RD_LAT(1)) dut (
        .clk(clk), .rst(rst), .start(start), .pattern(pattern), .busy(busy), .done(done),
        .pass(pass), .err_count(err), .first_err_addr(fea), .first_err_data(fed),
        .ram_we(we), .ram_re(re), .ram_addrA(aA), .ram_addrB(aB), .ram_dA(dA), .ram_dB(dB));
    always @(posedge clk) begin
        if (we) mem1[aA] <= dA;
        if (re) dB <= mem1[aB] | ((fault && aB == 4'd5) ? 18'd1 : 18'd0);
    end

    logic busy3, done3, pass3, we3, re3;
    logic [15:0] err3;
    logic [AW-1:0] fea3, aA3, aB3;
    logic [DW-1:0] fed3, dA3, dB3, r3a, r3b;
    logic [DW-1:0] mem3 [N];
    sram_march_tester #(.addr_w(AW), .data_w(DW), .RD_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .pattern(pattern), .busy(busy3), .done(done3),
        .pass(pass3), .err_count(err3), .first_err_addr(fea3), .first_err_data(fed3),
        .ram_we(we3), .ram_re(re3), .ram_addrA(aA3), .ram_addrB(aB3), .ram_dA(dA3), .ram_dB(dB3));
    always @(posedge clk) begin
        if (we3) mem3[aA3] <= dA3;
        r3a <= mem3[aB3];
        r3b <= r3a;
        dB3 <= r3b;
    end

    typedef struct packed {logic w; logic r; logic [AW-1:0] a; logic [DW-1:0] d;} acc_t;
    acc_t q[$];
    acc_t m_e;
    int checks = 0, errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_seq(input logic [DW-1:0] p);
        for (int a = 0; a < N; a++) q.push_back(acc_t'{1'b1, 1'b0, AW'(a), p});
        for (int a = 0; a < N; a++) begin
            q.push_back(acc_t'{1'b0, 1'b1, AW'(a), '0});
            q.push_back(acc_t'{1'b1, 1'b0, AW'(a), ~p});
        end
        for (int a = N - 1; a >= 0; a--) begin
            q.push_back(acc_t'{1'b0, 1'b1, AW'(a), '0});
            q.push_back(acc_t'{1'b1, 1'b0, AW'(a), p});
        end
        for (int a = 0; a < N; a++) q.push_back(acc_t'{1'b0, 1'b1, AW'(a), '0});
    endtask

    // every RAM access of the RD_LAT=1 instance is popped against the expected March order
    always @(negedge clk) begin
        if (!rst && (we || re)) begin
            check("we_and_re", 32'(we && re), 0);
            if (q.size() == 0) check("unexpected_access", 1, 0);
            else begin
                m_e = q.pop_front();
                check("acc_kind", {we, re}, {m_e.w, m_e.r});
                check("acc_addr", we ? aA : aB, m_e.a);
                if (we) check("acc_data", dA, m_e.d);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run1(input logic [DW-1:0] p, input bit flt, input bit hold, input int rst_at, output int n);
        pattern = p;
        fault = flt;
        start = 1;
        push_seq(p);
        tick();
        if (!hold) start = 0;
        check("done_clear", done, 0);
        check("busy_rise", busy, 1);
        n = 0;
        while (busy && n < 200) begin
            n++;
            if (n == rst_at) begin
                rst = 1;
                tick();
                rst = 0;
                q.delete();
                break;
            end
            tick();
        end
        start = 0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pass"}, pass, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_fea"}, fea, 0);
        check({tag, "_fed"}, fed, 0);
        check({tag, "_we_re"}, {we, re}, 0);
        check({tag, "_addr"}, {aA, aB}, 0);
        check({tag, "_dA"}, dA, 0);
    endtask

    int n, bad;
    initial begin
        repeat (3) tick();
        check_zero("reset");
        rst = 0;
        tick();

        run1(18'h2AAAA, 0, 0, 0, n);
        check("ff_busy_len", n, 97);
        check("ff_done", done, 1);
        check("ff_pass", pass, 1);
        check("ff_err", err, 0);
        check("ff_fea", fea, 0);
        bad = 0;
        for (int a = 0; a < N; a++) bad += int'(mem1[a] !== 18'h2AAAA);
        check("ff_ram_contents", bad, 0);
        check("ff_queue_empty", q.size(), 0);

        run1(18'h3FFFF, 0, 0, 0, n);
        check("order_busy_len", n, 97);
        check("order_pass", pass, 1);
        check("order_queue_empty", q.size(), 0);

        run1(18'h00000, 1, 0, 0, n);
        check("stuck_busy_len", n, 97);
        check("stuck_done", done, 1);
        check("stuck_pass", pass, 0);
        check("stuck_err", err, 2);
        check("stuck_fea", fea, EXP_FEA);
        check("stuck_fed", fed, EXP_FED);

        run1(18'h155AA, 0, 1, 0, n);
        check("hold_busy_len", n, 97);
        check("hold_done", done, 1);
        check("hold_pass", pass, 1);
        check("hold_err", err, 0);
        check("hold_fea", fea, 0);
        check("hold_fed", fed, 0);
        tick();
        check("hold_done_stays", done, 1);
        check("hold_queue_empty", q.size(), 0);

        run1(18'h2AAAA, 0, 0, 50, n);
        check("midrst_cycle", n, 50);
        check_zero("midrst");
        tick();
        check("midrst_still_idle", busy, 0);
        run1(18'h2AAAA, 0, 0, 0, n);
        check("rerun_busy_len", n, 97);
        check("rerun_done", done, 1);
        check("rerun_pass", pass, 1);
        check("rerun_err", err, 0);
        check("rerun_queue_empty", q.size(), 0);

        pattern = 18'h3FFFF;
        start3 = 1;
        tick();
        start3 = 0;
        check("lat3_busy_rise", busy3, 1);
        n = 0;
        while (busy3 && n < 200) begin
            n++;
            tick();
        end
        check("lat3_busy_len", n, 99);
        check("lat3_done", done3, 1);
        check("lat3_pass", pass3, 1);
        check("lat3_err", err3, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
